store_merge_buf: RTL and testbench

- Write-combining store buffer between the core's store port and the data-cache/bus write port.
- Accepts right-aligned store data with a one-hot size code and byte address, and builds the 8-bit byte-lane select.
- Aligns data into its 64-bit doubleword lane and merges consecutive stores to the same doubleword.
- Drains one doubleword write per handshake downstream with a per-byte strobe; flags loads that overlap pending stores.

---
 rtl/store_buf_pkg.sv | 28 ++
 rtl/st_lane_align.sv | 43 ++++
 rtl/store_merge_buf.sv | 148 ++++++++++++++
 tb/tb_store_merge_buf.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buf_pkg.sv
// Shared definitions for the store merge buffer.
//   SZ_B/SZ_H/SZ_W/SZ_D : one-hot store size codes (1/2/4/8 bytes)
//   size_bytes()        : byte count for a size code, 0 when not one-hot
//   ptr_w()             : entry pointer width derived from the buffer depth
package store_buf_pkg;

    localparam logic [3:0] SZ_B = 4'b0001;
    localparam logic [3:0] SZ_H = 4'b0010;
    localparam logic [3:0] SZ_W = 4'b0100;
    localparam logic [3:0] SZ_D = 4'b1000;

    localparam int SB_DEPTH = 4;

    function automatic logic [3:0] size_bytes(input logic [3:0] size);
        case (size)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            SZ_D:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/st_lane_align.sv
// Store lane alignment (combinational).
// Ports:
//   offset  in  3   byte offset within the doubleword (st_addr[2:0])
//   size    in  4   one-hot size code
//   data    in  64  right-aligned store data
//   mask    out 8   byte-lane select, zero for illegal stores
//   data_al out 64  data shifted into its lanes, unselected bytes zeroed
//   illegal out 1   size not one-hot, or store crosses the doubleword
module st_lane_align
    import store_buf_pkg::*;
(
    input  logic [2:0]  offset,
    input  logic [3:0]  size,
    input  logic [63:0] data,
    output logic [7:0]  mask,
    output logic [63:0] data_al,
    output logic        illegal
);

    logic [3:0]  nbytes;
    logic [7:0]  base;
    logic [63:0] byte_en;

    always_comb begin
        nbytes = size_bytes(size);
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            SZ_D:    base = 8'hFF;
            default: base = 8'h00;
        endcase
        // offset + bytes never exceeds 15, so a 4-bit sum is exact
        illegal = (nbytes == 4'd0) || (({1'b0, offset} + nbytes) > 4'd8);
        mask    = illegal ? 8'h00 : (base << offset);
        byte_en = '0;
        for (int i = 0; i < 8; i++) begin
            byte_en[8*i +: 8] = {8{mask[i]}};
        end
        data_al = (data << {offset, 3'b000}) & byte_en;
    end

endmodule

// File: rtl/store_merge_buf.sv
// Write-combining store buffer.
// Accepts right-aligned stores, aligns them into doubleword lanes, merges a
// store into the youngest entry when it hits the same doubleword (never into
// the head, which may be on the wb port), and drains entries in FIFO order.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   st_valid/st_ready               store handshake
//   st_addr/st_size/st_data         store byte address, one-hot size, data
//   st_err                          pulse: previous accepted store was illegal
//   ld_addr/ld_conflict             load doubleword hits a pending entry
//   flush/flush_done                disable merging; flush & empty
//   wb_valid/wb_ready               drain handshake
//   wb_addr/wb_data/wb_bsel         head entry address, lane data, strobes
//   empty/full                      occupancy flags
module store_merge_buf
    import store_buf_pkg::*;
#(
    parameter int PA_W  = 64,
    parameter int DEPTH = SB_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [PA_W-1:0] st_addr,
    input  logic [3:0]      st_size,
    input  logic [63:0]     st_data,
    output logic            st_err,
    input  logic [PA_W-1:0] ld_addr,
    output logic            ld_conflict,
    input  logic            flush,
    output logic            flush_done,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [PA_W-1:0] wb_addr,
    output logic [63:0]     wb_data,
    output logic [7:0]      wb_bsel,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int DW_W  = PA_W - 3;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

    logic [DEPTH-1:0] vld;
    logic [DW_W-1:0]  ent_dw   [DEPTH];
    logic [7:0]       ent_bsel [DEPTH];
    logic [63:0]      ent_data [DEPTH];

    logic [PTR_W-1:0] head, tail, young;
    logic [PTR_W:0]   count;

    logic [7:0]      mask;
    logic [63:0]     data_al;
    logic [63:0]     mask_bits;
    logic            illegal;
    logic [DW_W-1:0] st_dw;
    logic            merge_ok, st_fire, do_alloc, do_merge, wb_fire;

    st_lane_align u_align (
        .offset  (st_addr[2:0]),
        .size    (st_size),
        .data    (st_data),
        .mask    (mask),
        .data_al (data_al),
        .illegal (illegal)
    );

    assign st_dw = st_addr[PA_W-1:3];
    assign young = tail - 1'b1;
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // With two or more entries the youngest cannot be the head
    assign merge_ok = st_valid && !illegal && !flush && (count > ONE_CNT)
                      && (ent_dw[young] == st_dw);

    assign st_ready = !full || merge_ok;
    assign st_fire  = st_valid && st_ready;
    assign do_merge = st_fire && merge_ok;
    assign do_alloc = st_fire && !illegal && !merge_ok;

    assign wb_valid = !empty;
    assign wb_fire  = wb_valid && wb_ready;
    assign wb_addr  = {ent_dw[head], 3'b000};
    assign wb_data  = ent_data[head];
    assign wb_bsel  = ent_bsel[head];

    assign flush_done = flush && empty;

    always_comb begin
        mask_bits = '0;
        for (int i = 0; i < 8; i++) begin
            mask_bits[8*i +: 8] = {8{mask[i]}};
        end
    end

    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (ent_dw[i] == ld_addr[PA_W-1:3])) begin
                ld_conflict = 1'b1;
            end
        end
    end

    // Alloc writes tail, drain retires head; these only coincide when the
    // buffer is empty (no drain) or full (no alloc), so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            st_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_dw[i]   <= '0;
                ent_bsel[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            st_err <= st_fire && illegal;
            if (do_alloc) begin
                vld[tail]      <= 1'b1;
                ent_dw[tail]   <= st_dw;
                ent_bsel[tail] <= mask;
                ent_data[tail] <= data_al;
                tail           <= tail + 1'b1;
            end
            if (do_merge) begin
                ent_bsel[young] <= ent_bsel[young] | mask;
                ent_data[young] <= (ent_data[young] & ~mask_bits) | data_al;
            end
            if (wb_fire) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            case ({do_alloc, wb_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_buf.sv
module tb_store_merge_buf;

    localparam int PA_W  = 64;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            st_valid;
    logic            st_ready;
    logic [PA_W-1:0] st_addr;
    logic [3:0]      st_size;
    logic [63:0]     st_data;
    logic            st_err;
    logic [PA_W-1:0] ld_addr;
    logic            ld_conflict;
    logic            flush;
    logic            flush_done;
    logic            wb_valid;
    logic            wb_ready;
    logic [PA_W-1:0] wb_addr;
    logic [63:0]     wb_data;
    logic [7:0]      wb_bsel;
    logic            empty;
    logic            full;

    store_merge_buf #(.PA_W(PA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_size(st_size), .st_data(st_data), .st_err(st_err),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .flush(flush), .flush_done(flush_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_bsel(wb_bsel),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [60:0] dw;
        logic [7:0]  bsel;
        logic [63:0] data;
    } ent_t;

    ent_t mq[$];          // reference buffer contents, head at index 0
    bit   err_exp = 1'b0; // st_err expected in the coming cycle
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] expand(input logic [7:0] b);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) if (b[i]) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    // Reference model: evaluates the cycle's inputs against the pre-edge
    // buffer contents, checks outputs, then applies the accepted store.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (rst_n) begin
                int   n, off, nb;
                bit   legal, merge, ready, conf;
                logic [7:0] m;
                n   = mq.size();
                off = int'(st_addr[2:0]);
                nb  = $onehot(st_size) ? int'(st_size) : 0;
                legal = (nb != 0) && (off + nb <= 8);
                m = legal ? 8'(((1 << nb) - 1) << off) : 8'h00;
                merge = st_valid && legal && !flush && (n >= 2)
                        && (mq[n-1].dw == st_addr[63:3]);
                ready = (n < DEPTH) || merge;
                conf = 1'b0;
                foreach (mq[i]) if (mq[i].dw == ld_addr[63:3]) conf = 1'b1;

                chk("st_ready",    st_ready,    ready);
                chk("empty",       empty,       n == 0);
                chk("full",        full,        n == DEPTH);
                chk("wb_valid",    wb_valid,    n > 0);
                chk("flush_done",  flush_done,  flush && (n == 0));
                chk("ld_conflict", ld_conflict, conf);
                chk("st_err",      st_err,      err_exp);

                err_exp = 1'b0;
                if (st_valid && ready) begin
                    if (!legal) begin
                        err_exp = 1'b1;
                    end else begin
                        ent_t e;
                        if (merge) e = mq[n-1];
                        else begin
                            e.dw = st_addr[63:3];
                            e.bsel = 8'h00;
                            e.data = '0;
                        end
                        for (int b = 0; b < 8; b++) begin
                            if (m[b]) e.data[8*b +: 8] = st_data[8*(b-off) +: 8];
                        end
                        e.bsel = e.bsel | m;
                        if (merge) mq[n-1] = e;
                        else mq.push_back(e);
                    end
                end
            end
        end
    end

    // Scoreboard monitor: every drain handshake pops and compares the head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && wb_valid && wb_ready) begin
                if (mq.size() == 0) begin
                    chk("wb_unexpected", wb_addr, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    ent_t e;
                    e = mq.pop_front();
                    chk("wb_addr", wb_addr, {e.dw, 3'b000});
                    chk("wb_bsel", {56'h0, wb_bsel}, {56'h0, e.bsel});
                    chk("wb_data", wb_data & expand(e.bsel), e.data & expand(e.bsel));
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [63:0] a, input logic [3:0] sz,
                         input logic [63:0] d, input bit wbr, input bit fl,
                         input logic [63:0] ld);
        @(posedge clk);
        #1;
        st_valid = v;
        st_addr  = a;
        st_size  = sz;
        st_data  = d;
        wb_ready = wbr;
        flush    = fl;
        ld_addr  = ld;
    endtask

    task automatic idle(input int cycles, input bit wbr, input bit fl, input logic [63:0] ld);
        for (int i = 0; i < cycles; i++) drive(1'b0, 64'h0, 4'b0001, 64'h0, wbr, fl, ld);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        st_valid = 1'b0;
        wb_ready = 1'b0;
        flush    = 1'b0;
        mq.delete();
        err_exp = 1'b0;
        @(negedge clk);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_empty",    empty,    1'b1);
        chk("rst_st_ready", st_ready, 1'b1);
        chk("rst_wb_addr",  wb_addr,  64'h0);
        chk("rst_wb_data",  wb_data,  64'h0);
        chk("rst_wb_bsel",  {56'h0, wb_bsel}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] pool [4];
        pool[0] = 64'h1000; pool[1] = 64'h1008; pool[2] = 64'h2000; pool[3] = 64'h3000;
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_size = 4'b0001; st_data = '0;
        wb_ready = 1'b0; flush = 1'b0; ld_addr = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // single byte into empty buffer, held at the head
        drive(1, 64'h1003, 4'b0001, 64'hAB, 0, 0, 0);
        idle(1, 0, 0, 0);
        // stores behind a busy head, second and third merge
        drive(1, 64'h2000, 4'b1000, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
        drive(1, 64'h3002, 4'b0010, 64'h1234, 0, 0, 0);
        drive(1, 64'h3001, 4'b0001, 64'h77, 0, 0, 0);
        idle(2, 0, 0, 64'h3005);
        idle(1, 0, 0, 64'h3008);
        idle(6, 1, 0, 0);

        // no merge into the head
        drive(1, 64'h4000, 4'b0001, 64'h11, 0, 0, 0);
        drive(1, 64'h4001, 4'b0001, 64'h22, 0, 0, 0);
        idle(4, 1, 0, 0);

        // full stall and pointer wrap
        for (int i = 0; i < 4; i++)
            drive(1, 64'h6000 + 64'(i) * 8, 4'b0100, 64'(32'hA0 + i), 0, 0, 0);
        drive(1, 64'h7000, 4'b0001, 64'h5A, 0, 0, 0);
        drive(1, 64'h7000, 4'b0001, 64'h5A, 1, 0, 0);
        drive(1, 64'h7000, 4'b0001, 64'h5A, 0, 0, 0);
        idle(8, 1, 0, 0);

        // illegal stores on an empty buffer
        drive(1, 64'h5006, 4'b0100, 64'hCAFE_F00D, 0, 0, 0);
        drive(1, 64'h5000, 4'b0011, 64'h1, 0, 0, 0);
        idle(2, 0, 0, 0);

        // flush: pending entry, same-doubleword store allocates anyway
        drive(1, 64'h3000, 4'b0001, 64'h01, 0, 0, 0);
        drive(1, 64'h3008, 4'b0001, 64'h02, 0, 0, 0);
        drive(1, 64'h3009, 4'b0001, 64'h03, 0, 1, 64'h3005);
        idle(2, 0, 1, 64'h3008);
        idle(5, 1, 1, 0);

        // randomized traffic with a reset in the middle
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] sz;
            case ($urandom_range(0, 9))
                0:       sz = 4'($urandom_range(0, 15));
                1, 2:    sz = 4'b1000;
                3, 4:    sz = 4'b0100;
                5, 6:    sz = 4'b0010;
                default: sz = 4'b0001;
            endcase
            drive($urandom_range(0, 9) < 7,
                  pool[$urandom_range(0, 3)] | 64'($urandom_range(0, 7)),
                  sz, {$urandom, $urandom},
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 9) < 1,
                  pool[$urandom_range(0, 3)] | 64'($urandom_range(0, 7)));
            if (c == 1500) do_reset();
        end

        idle(12, 1, 1, 0);
        chk("final_drained", 64'(mq.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
